// File: rtl/i2c_scl_timer.sv
`default_nettype none
// ============================================================================
// Module      : i2c_scl_timer
// Description : I2C master SCL timebase. Each SCL cycle is split into four
//               quarter phases of P clk cycles each. SCL is pulled low in
//               phases 0-1 and released in phases 2-3. The slave may hold
//               the bus low and stretch phase 2.
// Ports       : clk           - single clock, rising-edge active
//               reset         - asynchronous, active-low
//               enable        - 1 = run SCL cycles, 0 = idle with SCL released
//               quarterPeriod - clk cycles per quarter SCL cycle (0 acts as 1)
//               stretchEn     - 1 = honour slave clock stretching
//               sclIn         - sensed bus SCL level (asynchronous)
//               sclOut        - SCL drive (0 = pull low, 1 = release)
//               phase         - current quarter phase 0..3
//               quarterTick   - one-clk pulse at the end of each quarter
//               cycleDone     - one-clk pulse at the 3->0 phase wrap
//               stretching    - 1 while phase 2 is held by a low bus SCL
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_scl_timer #(
    parameter int CNT_WIDTH      = 16,
    parameter int PERIOD_DEFAULT = 250
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [CNT_WIDTH-1:0] quarterPeriod,
    input  logic                 stretchEn,
    input  logic                 sclIn,
    output logic                 sclOut,
    output logic [1:0]           phase,
    output logic                 quarterTick,
    output logic                 cycleDone,
    output logic                 stretching
);

    localparam logic [1:0]           c_PH0        = 2'd0;
    localparam logic [1:0]           c_PH2        = 2'd2;
    localparam logic [1:0]           c_PH3        = 2'd3;
    localparam logic [CNT_WIDTH-1:0] c_ONE        = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] c_PERIOD_RST = CNT_WIDTH'(PERIOD_DEFAULT);

    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_running;
    logic [CNT_WIDTH-1:0] r_counter;
    logic [CNT_WIDTH-1:0] r_period;
    logic [1:0]           r_phase;
    logic                 r_sclOut;
    logic                 r_tick;
    logic                 r_done;
    logic                 r_stretch;

    logic [CNT_WIDTH-1:0] w_qpSafe;
    logic                 w_hold;
    logic                 w_expire;
    logic                 w_wrap;
    logic [1:0]           w_nextPhase;

    // A zero quarter period would never expire cleanly; treat it as one.
    assign w_qpSafe    = (quarterPeriod == '0) ? c_ONE : quarterPeriod;
    // Phase 2 is held while the bus is still seen low (slave stretching).
    assign w_hold      = (r_phase == c_PH2) && stretchEn && !r_sync2;
    // The >= compare also bounds the counter below its all-ones wrap.
    assign w_expire    = !w_hold && (r_counter >= r_period);
    assign w_wrap      = w_expire && (r_phase == c_PH3);
    assign w_nextPhase = r_phase + 2'd1;

    // Bus SCL synchroniser; idles high like a released bus.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= sclIn;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_running <= 1'b0;
            r_counter <= c_ONE;
            r_period  <= c_PERIOD_RST;
            r_phase   <= c_PH0;
            r_sclOut  <= 1'b1;
            r_tick    <= 1'b0;
            r_done    <= 1'b0;
            r_stretch <= 1'b0;
        end else if (!enable) begin
            // Idle: release SCL and park at the start of phase 0.
            r_running <= 1'b0;
            r_counter <= c_ONE;
            r_phase   <= c_PH0;
            r_sclOut  <= 1'b1;
            r_tick    <= 1'b0;
            r_done    <= 1'b0;
            r_stretch <= 1'b0;
        end else if (!r_running) begin
            // First enabled edge: latch the period and pull SCL low at once.
            r_running <= 1'b1;
            r_counter <= c_ONE;
            r_period  <= w_qpSafe;
            r_phase   <= c_PH0;
            r_sclOut  <= 1'b0;
            r_tick    <= 1'b0;
            r_done    <= 1'b0;
            r_stretch <= 1'b0;
        end else begin
            r_tick    <= w_expire;
            r_done    <= w_wrap;
            r_stretch <= w_hold;
            if (w_hold) begin
                r_counter <= c_ONE;
            end else if (w_expire) begin
                r_counter <= c_ONE;
                r_phase   <= w_nextPhase;
                r_sclOut  <= w_nextPhase[1];
                // The new period takes effect only from the next SCL cycle.
                if (w_wrap) begin
                    r_period <= w_qpSafe;
                end
            end else begin
                r_counter <= r_counter + c_ONE;
            end
        end
    end

    assign sclOut      = r_sclOut;
    assign phase       = r_phase;
    assign quarterTick = r_tick;
    assign cycleDone   = r_done;
    assign stretching  = r_stretch;

endmodule
`default_nettype wire

// File: tb/tb_i2c_scl_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_scl_timer
// Description : Directed self-checking bench for i2c_scl_timer. Outputs are
//               packed as {sclOut, phase, quarterTick, cycleDone, stretching}
//               and sampled on the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_scl_timer;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [15:0] quarterPeriod;
    logic        stretchEn;
    logic        sclIn;
    logic        slaveRelease;
    logic        sclOut;
    logic [1:0]  phase;
    logic        quarterTick;
    logic        cycleDone;
    logic        stretching;

    int nCompared;
    int nMismatched;

    // Open-drain bus: low if the master or the slave pulls it low.
    assign sclIn = sclOut & slaveRelease;

    i2c_scl_timer #(
        .CNT_WIDTH      (16),
        .PERIOD_DEFAULT (250)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .quarterPeriod (quarterPeriod),
        .stretchEn     (stretchEn),
        .sclIn         (sclIn),
        .sclOut        (sclOut),
        .phase         (phase),
        .quarterTick   (quarterTick),
        .cycleDone     (cycleDone),
        .stretching    (stretching)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [5:0] c_IDLE = 6'b1_00_0_0_0;

    // Expected outputs t edges after the start edge of a free-running cycle.
    function automatic logic [5:0] expNormal(int t, int p);
        int   ph;
        logic tk;
        logic dn;
        ph = (t / p) % 4;
        tk = (t > 0) && (t % p == 0);
        dn = (t > 0) && (t % (4 * p) == 0);
        return {(ph >= 2), 2'(ph), tk, dn, 1'b0};
    endfunction

    function automatic logic [5:0] observed();
        return {sclOut, phase, quarterTick, cycleDone, stretching};
    endfunction

    task automatic startRun(input logic [15:0] qp);
        enable = 1'b0;
        @(negedge clk);
        quarterPeriod = qp;
        enable        = 1'b1;
    endtask

    task automatic test_reset();
        logic [5:0] got;
        reset = 1'b0; enable = 1'b0; quarterPeriod = 16'd4;
        stretchEn = 1'b0; slaveRelease = 1'b1;
        repeat (2) @(negedge clk);
        got = observed();
        nCompared++;
        if (got !== c_IDLE) begin
            nMismatched++;
            $display("FAIL reset_state got=%b exp=%b", got, c_IDLE);
        end
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            got = observed();
            nCompared++;
            if (got !== c_IDLE) begin
                nMismatched++;
                $display("FAIL idle_after_reset k=%0d got=%b exp=%b", k, got, c_IDLE);
            end
        end
    endtask

    task automatic test_basic(input logic [15:0] qp, input int p, input int n);
        logic [5:0] got;
        logic [5:0] exp;
        startRun(qp);
        for (int t = 0; t < n; t++) begin
            @(negedge clk);
            got = observed();
            exp = expNormal(t, p);
            nCompared++;
            if (got !== exp) begin
                nMismatched++;
                $display("FAIL basic_p%0d t=%0d got=%b exp=%b", p, t, got, exp);
            end
        end
    endtask

    task automatic test_period_change();
        logic [5:0] got;
        logic [5:0] exp;
        int u;
        startRun(16'd4);
        for (int t = 0; t < 62; t++) begin
            @(negedge clk);
            got = observed();
            if (t < 16) begin
                exp = expNormal(t, 4);
            end else begin
                u   = t - 16;
                exp = (u == 0) ? 6'b0_00_1_1_0 : expNormal(u, 10);
            end
            nCompared++;
            if (got !== exp) begin
                nMismatched++;
                $display("FAIL period_change t=%0d got=%b exp=%b", t, got, exp);
            end
            if (t == 5) quarterPeriod = 16'd10;
        end
    endtask

    task automatic test_stretch();
        logic [5:0] got;
        logic [5:0] exp;
        stretchEn    = 1'b1;
        slaveRelease = 1'b0;
        startRun(16'd4);
        for (int t = 0; t <= 38; t++) begin
            @(negedge clk);
            got = observed();
            if (t < 8)       exp = expNormal(t, 4);
            else if (t < 34) exp = {1'b1, 2'd2, (t == 8), 1'b0, (t >= 9 && t <= 30)};
            else if (t < 38) exp = {1'b1, 2'd3, (t == 34), 1'b0, 1'b0};
            else             exp = 6'b0_00_1_1_0;
            nCompared++;
            if (got !== exp) begin
                nMismatched++;
                $display("FAIL stretch t=%0d got=%b exp=%b", t, got, exp);
            end
            if (t == 28) slaveRelease = 1'b1;
        end
        stretchEn = 1'b0;
    endtask

    task automatic test_enable_drop();
        logic [5:0] got;
        logic [5:0] exp;
        startRun(16'd4);
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            got = observed();
            exp = expNormal(t, 4);
            nCompared++;
            if (got !== exp) begin
                nMismatched++;
                $display("FAIL enable_drop_pre t=%0d got=%b exp=%b", t, got, exp);
            end
        end
        enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            got = observed();
            nCompared++;
            if (got !== c_IDLE) begin
                nMismatched++;
                $display("FAIL enable_drop_idle k=%0d got=%b exp=%b", k, got, c_IDLE);
            end
        end
        enable = 1'b1;
        for (int t = 0; t < 17; t++) begin
            @(negedge clk);
            got = observed();
            exp = expNormal(t, 4);
            nCompared++;
            if (got !== exp) begin
                nMismatched++;
                $display("FAIL reenable t=%0d got=%b exp=%b", t, got, exp);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [5:0] got;
        stretchEn    = 1'b1;
        slaveRelease = 1'b0;
        startRun(16'd4);
        repeat (16) @(negedge clk);
        nCompared++;
        if (stretching !== 1'b1) begin
            nMismatched++;
            $display("FAIL pre_reset_stretching got=%b exp=1", stretching);
        end
        #2 reset = 1'b0;
        #1;
        got = observed();
        nCompared++;
        if (got !== c_IDLE) begin
            nMismatched++;
            $display("FAIL async_reset got=%b exp=%b", got, c_IDLE);
        end
        nCompared++;
        if (dut.r_period !== 16'd250) begin
            nMismatched++;
            $display("FAIL reset_period got=%0d exp=250", dut.r_period);
        end
        enable       = 1'b0;
        stretchEn    = 1'b0;
        slaveRelease = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            got = observed();
            nCompared++;
            if (got !== c_IDLE) begin
                nMismatched++;
                $display("FAIL idle_after_async_reset k=%0d got=%b exp=%b", k, got, c_IDLE);
            end
        end
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        test_reset();
        test_basic(16'd4, 4, 40);
        test_period_change();
        test_basic(16'd0, 1, 12);
        test_stretch();
        test_enable_drop();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
`default_nettype wire
